// File: rtl/cache_maint_ctrl.sv
// Clear/flush sequencer: fans one maintenance request out to the enabled caches,
// in parallel or in index order, and folds their completions into one done pulse.
module cache_maint_ctrl #(
    parameter int unsigned NUM_CACHES     = 2,
    parameter int unsigned SEQUENTIAL     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clear_req,
    input  logic                  flush_req,
    input  logic [NUM_CACHES-1:0] cache_en,
    output logic [NUM_CACHES-1:0] cache_clear,
    output logic [NUM_CACHES-1:0] cache_flush,
    input  logic [NUM_CACHES-1:0] cache_clear_done,
    input  logic [NUM_CACHES-1:0] cache_flush_done,
    output logic                  busy,
    output logic                  maint_done,
    output logic                  timeout_err
);

    localparam int unsigned NW = NUM_CACHES;
    localparam int unsigned IW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic          op_flush;
    logic          clear_pend;
    logic          flush_pend;
    logic          gap;
    logic [NW-1:0] en_mask;
    logic [NW-1:0] seen;
    logic [IW-1:0] idx;
    logic [TW-1:0] tcnt;

    logic          take;
    logic          take_flush;
    logic [NW-1:0] start_drive;
    logic [NW-1:0] done_vec;
    logic [NW-1:0] seen_nx;
    logic [NW-1:0] drive_nx;
    logic [NW-1:0] idx_bit;
    logic [IW-1:0] first_idx;
    logic [IW-1:0] next_idx;
    logic [IW-1:0] idx_nx;
    logic          next_vld;
    logic          gap_nx;
    logic          got;
    logic          all_done;
    logic          abort;

    // Completion tracking and next-cycle drive pattern for ISSUE/WAIT
    always_comb begin
        take        = clear_req | flush_req | clear_pend | flush_pend;
        take_flush  = flush_req | flush_pend;
        done_vec    = op_flush ? cache_flush_done : cache_clear_done;
        idx_bit     = NW'(1) << idx;
        first_idx   = '0;
        next_idx    = '0;
        next_vld    = 1'b0;
        for (int i = NUM_CACHES - 1; i >= 0; i--) begin
            if (cache_en[i]) first_idx = IW'(i);
            if (en_mask[i] && (i > int'(idx))) begin
                next_idx = IW'(i);
                next_vld = 1'b1;
            end
        end
        seen_nx  = seen;
        drive_nx = '0;
        got      = 1'b0;
        all_done = 1'b0;
        gap_nx   = 1'b0;
        idx_nx   = idx;
        if (SEQUENTIAL != 0) begin
            start_drive = (cache_en == '0) ? '0 : (NW'(1) << first_idx);
            if (en_mask == '0) begin
                all_done = 1'b1;
            end else if (gap) begin
                drive_nx = idx_bit;
            end else if (done_vec[idx]) begin
                // Current cache finished: one idle cycle, then the next enabled one
                got      = 1'b1;
                all_done = !next_vld;
                gap_nx   = next_vld;
                idx_nx   = next_vld ? next_idx : idx;
            end else begin
                drive_nx = idx_bit;
            end
        end else begin
            start_drive = cache_en;
            got         = |(done_vec & en_mask & ~seen);
            seen_nx     = seen | (done_vec & en_mask);
            all_done    = (seen_nx == en_mask);
            drive_nx    = en_mask & ~seen_nx;
        end
        abort = (state == WAIT) && (TIMEOUT_CYCLES != 0) && !got &&
                (tcnt == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            op_flush    <= 1'b0;
            clear_pend  <= 1'b0;
            flush_pend  <= 1'b0;
            gap         <= 1'b0;
            en_mask     <= '0;
            seen        <= '0;
            idx         <= '0;
            tcnt        <= '0;
            cache_clear <= '0;
            cache_flush <= '0;
            busy        <= 1'b0;
            maint_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state != IDLE) begin
                if (clear_req) clear_pend <= 1'b1;
                if (flush_req) flush_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (take) begin
                        // A flush also covers any clear, so both pending bits retire
                        state       <= ISSUE;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        clear_pend  <= 1'b0;
                        flush_pend  <= 1'b0;
                        op_flush    <= take_flush;
                        en_mask     <= cache_en;
                        seen        <= '0;
                        idx         <= first_idx;
                        gap         <= 1'b0;
                        tcnt        <= '0;
                        cache_flush <= take_flush ? start_drive : '0;
                        cache_clear <= take_flush ? '0 : start_drive;
                    end
                end
                ISSUE, WAIT: begin
                    seen <= seen_nx;
                    idx  <= idx_nx;
                    gap  <= gap_nx;
                    if (all_done || abort) begin
                        state       <= DONE;
                        maint_done  <= 1'b1;
                        cache_clear <= '0;
                        cache_flush <= '0;
                        if (abort) timeout_err <= 1'b1;
                    end else begin
                        state       <= WAIT;
                        cache_flush <= op_flush ? drive_nx : '0;
                        cache_clear <= op_flush ? '0 : drive_nx;
                        tcnt        <= ((state == ISSUE) || got) ? '0 : tcnt + TW'(1);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    maint_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_maint_ctrl.sv
// Directed bench for cache_maint_ctrl: a parallel 2-cache instance with a short
// timeout and a sequential 3-cache instance, checked cycle by cycle.
module tb_cache_maint_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       p_clr, p_fl, p_busy, p_md, p_te;
    logic [1:0] p_en, p_cc, p_cf, p_cd, p_fd;

    logic       s_clr, s_fl, s_busy, s_md, s_te;
    logic [2:0] s_en, s_cc, s_cf, s_cd, s_fd;

    cache_maint_ctrl #(.NUM_CACHES(2), .SEQUENTIAL(0), .TIMEOUT_CYCLES(8)) dut_p (
        .CLK(clk), .RST(rst), .clear_req(p_clr), .flush_req(p_fl), .cache_en(p_en),
        .cache_clear(p_cc), .cache_flush(p_cf), .cache_clear_done(p_cd),
        .cache_flush_done(p_fd), .busy(p_busy), .maint_done(p_md), .timeout_err(p_te)
    );

    cache_maint_ctrl #(.NUM_CACHES(3), .SEQUENTIAL(1), .TIMEOUT_CYCLES(8)) dut_s (
        .CLK(clk), .RST(rst), .clear_req(s_clr), .flush_req(s_fl), .cache_en(s_en),
        .cache_clear(s_cc), .cache_flush(s_cf), .cache_clear_done(s_cd),
        .cache_flush_done(s_fd), .busy(s_busy), .maint_done(s_md), .timeout_err(s_te)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        p_clr = 0; p_fl = 0; p_en = '0; p_cd = '0; p_fd = '0;
        s_clr = 0; s_fl = 0; s_en = '0; s_cd = '0; s_fd = '0;
        tick; tick;
        rst = 1'b0;
        tick;
        chk("rst_p_cc", 8'(p_cc), 8'h0);
        chk("rst_p_busy", 8'(p_busy), 8'h0);
        chk("rst_p_md", 8'(p_md), 8'h0);
        chk("rst_s_cf", 8'(s_cf), 8'h0);

        // Parallel clear, dones out of order
        p_en = 2'b11; p_clr = 1; tick;
        p_clr = 0;
        chk("par_t1_cc", 8'(p_cc), 8'h3);
        chk("par_t1_busy", 8'(p_busy), 8'h1);
        chk("par_t1_cf", 8'(p_cf), 8'h0);
        tick;
        tick;
        p_cd = 2'b10;
        chk("par_t3_cc", 8'(p_cc), 8'h3);
        tick;
        p_cd = 2'b00;
        chk("par_t4_cc", 8'(p_cc), 8'h1);
        chk("par_t4_md", 8'(p_md), 8'h0);
        tick;
        p_cd = 2'b01;
        chk("par_t5_cc", 8'(p_cc), 8'h1);
        tick;
        p_cd = 2'b00;
        chk("par_t6_cc", 8'(p_cc), 8'h0);
        chk("par_t6_md", 8'(p_md), 8'h1);
        chk("par_t6_busy", 8'(p_busy), 8'h1);
        tick;
        chk("par_t7_md", 8'(p_md), 8'h0);
        chk("par_t7_busy", 8'(p_busy), 8'h0);

        // Simultaneous clear+flush: flush only, clear dones ignored, nothing queued
        p_clr = 1; p_fl = 1; tick;
        p_clr = 0; p_fl = 0;
        chk("both_t1_cf", 8'(p_cf), 8'h3);
        chk("both_t1_cc", 8'(p_cc), 8'h0);
        p_cd = 2'b11;
        tick;
        p_cd = 2'b00;
        chk("both_t2_cf", 8'(p_cf), 8'h3);
        chk("both_t2_md", 8'(p_md), 8'h0);
        p_fd = 2'b11;
        tick;
        p_fd = 2'b00;
        chk("both_t3_cf", 8'(p_cf), 8'h0);
        chk("both_t3_md", 8'(p_md), 8'h1);
        tick;
        chk("both_t4_busy", 8'(p_busy), 8'h0);
        tick;
        chk("both_t5_busy", 8'(p_busy), 8'h0);

        // Two clear requests during a busy flush merge into one follow-up clear
        p_fl = 1; tick;
        p_fl = 0; p_clr = 1; tick;
        tick;
        p_clr = 0; p_fd = 2'b11;
        chk("q_t3_cf", 8'(p_cf), 8'h3);
        tick;
        p_fd = 2'b00;
        chk("q_t4_md", 8'(p_md), 8'h1);
        chk("q_t4_cf", 8'(p_cf), 8'h0);
        tick;
        chk("q_t5_busy", 8'(p_busy), 8'h0);
        chk("q_t5_cc", 8'(p_cc), 8'h0);
        tick;
        chk("q_t6_cc", 8'(p_cc), 8'h3);
        chk("q_t6_busy", 8'(p_busy), 8'h1);
        p_cd = 2'b11;
        tick;
        p_cd = 2'b00;
        chk("q_t7_md", 8'(p_md), 8'h1);
        chk("q_t7_cc", 8'(p_cc), 8'h0);
        tick;
        chk("q_t8_busy", 8'(p_busy), 8'h0);
        tick;
        chk("q_t9_busy", 8'(p_busy), 8'h0);
        chk("q_t9_md", 8'(p_md), 8'h0);

        // Timeout: cache 0 never answers; cache_en change mid-op is ignored
        p_en = 2'b01; p_clr = 1; tick;
        p_clr = 0; p_en = 2'b11;
        chk("to_t1_cc", 8'(p_cc), 8'h1);
        repeat (8) tick;
        chk("to_t9_cc", 8'(p_cc), 8'h1);
        chk("to_t9_te", 8'(p_te), 8'h0);
        chk("to_t9_md", 8'(p_md), 8'h0);
        tick;
        chk("to_t10_cc", 8'(p_cc), 8'h0);
        chk("to_t10_te", 8'(p_te), 8'h1);
        chk("to_t10_md", 8'(p_md), 8'h1);
        tick;
        chk("to_t11_md", 8'(p_md), 8'h0);
        chk("to_t11_te", 8'(p_te), 8'h1);
        chk("to_t11_busy", 8'(p_busy), 8'h0);

        // Empty enable mask: done two cycles after the request; clears timeout_err
        p_en = 2'b00; p_clr = 1; tick;
        p_clr = 0;
        chk("emp_t1_te", 8'(p_te), 8'h0);
        chk("emp_t1_cc", 8'(p_cc), 8'h0);
        chk("emp_t1_busy", 8'(p_busy), 8'h1);
        chk("emp_t1_md", 8'(p_md), 8'h0);
        tick;
        chk("emp_t2_md", 8'(p_md), 8'h1);
        chk("emp_t2_cc", 8'(p_cc), 8'h0);
        tick;
        chk("emp_t3_busy", 8'(p_busy), 8'h0);

        // Asynchronous reset in WAIT
        p_en = 2'b11; p_clr = 1; tick;
        p_clr = 0; tick;
        chk("rw_t2_cc", 8'(p_cc), 8'h3);
        #2 rst = 1'b1;
        #1;
        chk("rw_async_cc", 8'(p_cc), 8'h0);
        chk("rw_async_busy", 8'(p_busy), 8'h0);
        tick;
        rst = 1'b0;
        tick;
        chk("rw_rel_busy", 8'(p_busy), 8'h0);
        chk("rw_rel_cc", 8'(p_cc), 8'h0);
        p_cd = 2'b11; tick;
        p_cd = 2'b00;
        chk("rw_rel_md", 8'(p_md), 8'h0);

        // Sequential flush over caches 0 and 2, cache 1 disabled
        s_en = 3'b101; s_fl = 1; tick;
        s_fl = 0;
        chk("seq_t1_cf", 8'(s_cf), 8'h1);
        chk("seq_t1_cc", 8'(s_cc), 8'h0);
        chk("seq_t1_busy", 8'(s_busy), 8'h1);
        tick;
        chk("seq_t2_cf", 8'(s_cf), 8'h1);
        s_fd = 3'b001;
        tick;
        s_fd = 3'b000;
        chk("seq_t3_cf", 8'(s_cf), 8'h0);
        chk("seq_t3_md", 8'(s_md), 8'h0);
        tick;
        chk("seq_t4_cf", 8'(s_cf), 8'h4);
        s_fd = 3'b010;
        tick;
        chk("seq_t5_cf", 8'(s_cf), 8'h4);
        s_fd = 3'b100;
        tick;
        s_fd = 3'b000;
        chk("seq_t6_cf", 8'(s_cf), 8'h0);
        chk("seq_t6_md", 8'(s_md), 8'h1);
        tick;
        chk("seq_t7_md", 8'(s_md), 8'h0);
        chk("seq_t7_busy", 8'(s_busy), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_maint_ctrl.md
Name: cache_maint_ctrl

Overview:
- Parametrised clear/flush sequencer between the core's maintenance request (fence.i, CSR-driven flush) and N caches, each exposing the clear/flush + clear_done/flush_done handshake.
- Fans one request out to all enabled caches, either in parallel or one at a time, and aggregates completions into a single done pulse.
- Queues requests that arrive while busy and aborts hung caches with a timeout.

Parameters:
- NUM_CACHES, 2, number of downstream caches (1..16).
- SEQUENTIAL, 0, 0 = issue to all enabled caches at once; 1 = issue in index order 0..N-1, one cache at a time.
- TIMEOUT_CYCLES, 4096, cycles without any new done before abort; 0 disables the timeout.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- clear_req  in  1  single-cycle request to invalidate all enabled caches.
- flush_req  in  1  single-cycle request to write back and invalidate all enabled caches.
- cache_en  in  NUM_CACHES  per-cache enable; sampled when an operation starts.
- cache_clear  out  NUM_CACHES  per-cache clear, level-held until that cache's done.
- cache_flush  out  NUM_CACHES  per-cache flush, level-held until that cache's done.
- cache_clear_done  in  NUM_CACHES  per-cache clear completion.
- cache_flush_done  in  NUM_CACHES  per-cache flush completion.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- maint_done  out  1  one-cycle pulse when the operation completes or aborts.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): FSM = IDLE, and all of the following clear to 0: outputs, pending bits, seen mask, index, timeout counter. Caches receive no further clear or flush requests.
- States:
  - IDLE: waiting for a request or pending bit.
  - ISSUE: latch op type and en_mask = cache_en; clear seen mask; drive outputs.
  - WAIT: hold outputs until the op completes or times out.
  - DONE: maint_done = 1 for exactly 1 cycle, then IDLE.
- Acceptance: in IDLE, a request or a pending bit moves the FSM to ISSUE next cycle.
  - Op type is flush if flush_req or flush_pend is set, else clear. Flush is a superset of clear, so when both are active the flush services both and clears both pending bits.
  - Pending bits are consumed when taken.
- Requests while not IDLE set clear_pend / flush_pend. Repeats merge into the single bit; nothing else is queued.
- Latency: request at cycle t → busy and cache_* asserted at t+1 (ISSUE); all outputs are registered.
- Only the output matching the op type drives. A done on the other type's input is ignored.
- PARALLEL mode (SEQUENTIAL = 0):
  - ISSUE asserts the op for every en_mask bit.
  - In WAIT, done[i] sets seen[i]; that cache's request deasserts the next cycle.
  - When seen == en_mask the FSM goes to DONE. Dones may arrive in any order, including in the same cycle.
- SEQUENTIAL mode (SEQUENTIAL = 1):
  - A $clog2(NUM_CACHES)-bit idx starts at the lowest enabled index; only cache idx is driven.
  - On done[idx], deassert next cycle and advance idx to the next enabled index. There is one idle cycle between caches.
  - After the last enabled cache, go to DONE.
- en_mask all zero: ISSUE → DONE directly, giving maint_done at t+2 with no cache driven.
- Done arriving the same cycle the request is first driven (ISSUE) counts.
- Timeout:
  - The counter (width $clog2(TIMEOUT_CYCLES+1)) resets on entry to WAIT and on any newly seen done, and increments otherwise.
  - At TIMEOUT_CYCLES: drop all cache_* next cycle, set timeout_err, go to DONE.
  - timeout_err stays set until reset or the next accepted request.
- cache_en changes during an op are ignored until the next ISSUE.

Test Plan:
- N=2, parallel: clear_req at t; cache 1 done at t+3, cache 0 done at t+5 → cache_clear = 2'b11 at t+1, 2'b01 at t+4, 2'b00 at t+6; maint_done only at t+6; busy t+1..t+6.
- N=3, sequential, cache_en = 3'b101, flush_req: cache_flush = 001 until cache 0 done, then 000 for one cycle, then 100; cache 1 is never driven; one maint_done after cache 2's done.
- Simultaneous clear_req and flush_req in IDLE → only cache_flush driven, clear_pend = 0, a single maint_done.
- clear_req twice during a busy flush → after the flush's maint_done, exactly one clear op runs (IDLE → ISSUE the next cycle), then a second maint_done.
- TIMEOUT_CYCLES = 8, cache 0 never responds → outputs drop and timeout_err = 1 on the 9th WAIT cycle, maint_done pulses once; the next clear_req clears timeout_err.
- cache_en = 0 with clear_req at t → no cache_clear asserted, maint_done at t+2. Separately, RST asserted mid-WAIT → all outputs 0 asynchronously and FSM in IDLE after release.
